alu4_reg: RTL and testbench
===========================

Name: alu4_reg

Overview:
- Registered 4-bit two-operation ALU (two's-complement add, bitwise NAND) for the 4-bit CPU datapath.
- Produces result, operand-equality flag and signed-overflow flag.
- Operands are sampled on a valid strobe; outputs are registered with one-cycle latency.
- Sits between the register file read ports and the writeback/branch logic.

Parameters:
- WIDTH, 4, operand/result width in bits. Only 4 is required; RTL must be written generically.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and sel valid this cycle; capture on rising clk edge
- A  input  WIDTH  operand A, two's complement
- B  input  WIDTH  operand B, two's complement
- sel  input  1  operation select: 0 = A+B, 1 = ~(A&B)
- RES  output  WIDTH  registered result
- eq  output  1  registered flag, 1 when A == B (bitwise, all WIDTH bits)
- ovf  output  1  registered signed-overflow flag (add only)
- out_valid  output  1  high for one cycle when RES/eq/ovf carry a new result
- (ovf_sticky, ovf_clr: present only with the optional feature, see below)

Behaviour:
- Reset: asynchronous on rst_n low; RES=0, eq=0, ovf=0, out_valid=0 (and ovf_sticky=0). Outputs are held while rst_n is low.
- Reset deasserts synchronously into normal operation at the next rising clk edge.
- Reset mid-operation discards any captured-but-unpublished result.
- Latency: in_valid sampled at edge N -> RES/eq/ovf updated and out_valid=1 after edge N.
- out_valid=1 for exactly one cycle per accepted input. Back-to-back in_valid on consecutive cycles gives one result per cycle.
- in_valid=0: RES/eq/ovf hold their previous values; out_valid=0.
- sel=0 (add):
  - RES = (A+B) mod 2^WIDTH; carry-out discarded.
  - ovf = 1 iff A[MSB]==B[MSB] and RES[MSB]!=A[MSB].
- sel=1 (nand):
  - RES = ~(A & B) bitwise.
  - ovf = 0.
- eq = (A == B), computed for both operations, independent of sel.
- No handshake backpressure; the consumer must accept every out_valid pulse.
- X on sel while in_valid=1 is illegal; verification must not drive it.

Optional Feature:
- Macro: ALU_OVF_STICKY_EN.
- Defined:
  - Adds input ovf_clr (1 bit) and output ovf_sticky (1 bit).
  - ovf_sticky is set on any clock edge that publishes ovf=1 and stays set until ovf_clr=1 is sampled.
  - Simultaneous set and clear: set wins (sticky ends at 1).
  - Reset value is 0.
- Undefined: neither port exists; the remaining behaviour is identical.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> RES=0, eq=0, ovf=0, out_valid=0 immediately, without waiting for a clock edge.
- Add, no overflow: A=4'b1111, B=4'b1011, sel=0, in_valid=1 -> next cycle RES=4'b1010 (-6), eq=0, ovf=0, out_valid=1.
- NAND, equal operands: A=4'b1110, B=4'b1110, sel=1 -> RES=4'b0001, eq=1, ovf=0.
- Negative overflow: A=4'b1000, B=4'b1101, sel=0 -> RES=4'b0101, eq=0, ovf=1.
- Positive overflow: A=4'b0101, B=4'b0101, sel=0 -> RES=4'b1010, eq=1, ovf=1.
- Hold and sticky: drop in_valid after the positive-overflow case -> outputs hold and out_valid=0. With ALU_OVF_STICKY_EN, ovf_sticky stays 1 until ovf_clr pulses, then reads 0.

Source files
------------

// File: rtl/alu4_reg.sv
// Registered two-operation ALU (add / NAND) with equality and signed-overflow flags.
// Optional sticky overflow flag with clear input is enabled by defining ALU_OVF_STICKY_EN.
module alu4_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef ALU_OVF_STICKY_EN
   input  logic             ovf_clr,
   output logic             ovf_sticky,
`endif
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sel,
   output logic [WIDTH-1:0] RES,
   output logic             eq,
   output logic             ovf,
   output logic             out_valid
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] res_q, res_d;
   logic             eq_q, eq_d;
   logic             ovf_q, ovf_d;
   logic             valid_q;

   logic [WIDTH-1:0] sumVal;
   logic [WIDTH-1:0] nandVal;
   logic             addOvf;

   assign sumVal  = A + B;
   assign nandVal = ~(A & B);
   assign addOvf  = (A[MSB] == B[MSB]) && (sumVal[MSB] != A[MSB]);

   // Outputs only move when a new operand set is accepted; otherwise they hold.
   always_comb begin
      res_d = res_q;
      eq_d  = eq_q;
      ovf_d = ovf_q;
      if (in_valid) begin
         res_d = sel ? nandVal : sumVal;
         eq_d  = (A == B);
         ovf_d = sel ? 1'b0 : addOvf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         eq_q    <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         eq_q    <= eq_d;
         ovf_q   <= ovf_d;
         valid_q <= in_valid;
      end
   end

`ifdef ALU_OVF_STICKY_EN
   logic sticky_q, sticky_d;
   logic stickySet;

   // A publishing overflow beats a simultaneous clear so no event is lost.
   assign stickySet = in_valid && !sel && addOvf;

   always_comb begin
      sticky_d = sticky_q;
      if (ovf_clr) begin
         sticky_d = 1'b0;
      end
      if (stickySet) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign ovf_sticky = sticky_q;
`endif

   assign RES       = res_q;
   assign eq        = eq_q;
   assign ovf       = ovf_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_alu4_reg.sv
// Scoreboard bench for alu4_reg: directed vectors push expected results, a negedge monitor pops and compares.
// Sticky-flag checks are compiled in when ALU_OVF_STICKY_EN is defined.
module tb_alu4_reg;

   localparam int WIDTH = 4;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             eq;
      logic             ovf;
   } expT;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sel;
   logic [WIDTH-1:0] RES;
   logic             eq;
   logic             ovf;
   logic             out_valid;
`ifdef ALU_OVF_STICKY_EN
   logic             ovf_clr;
   logic             ovf_sticky;
`endif

   expT expQueue[$];
   int  total = 0;
   int  bad   = 0;

   alu4_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef ALU_OVF_STICKY_EN
      .ovf_clr   (ovf_clr),
      .ovf_sticky(ovf_sticky),
`endif
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .RES       (RES),
      .eq        (eq),
      .ovf       (ovf),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkField(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Drive one operand set for one edge; in_valid is left high so calls back-to-back stream.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                                input logic [WIDTH-1:0] er, input logic ee, input logic eo);
      expT e;
      A        = a;
      B        = b;
      sel      = s;
      in_valid = 1'b1;
      e.res = er;
      e.eq  = ee;
      e.ovf = eo;
      expQueue.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] er, input logic ee,
                              input logic eo, input logic ev);
      checkField({name, ".RES"}, int'(RES), int'(er));
      checkField({name, ".eq"}, int'(eq), int'(ee));
      checkField({name, ".ovf"}, int'(ovf), int'(eo));
      checkField({name, ".out_valid"}, int'(out_valid), int'(ev));
   endtask

   // Monitor: every out_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      expT e;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         if (expQueue.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_out_valid: got RES=%0d with no pending result", RES);
         end else begin
            e = expQueue.pop_front();
            checkField("sb.RES", int'(RES), int'(e.res));
            checkField("sb.eq", int'(eq), int'(e.eq));
            checkField("sb.ovf", int'(ovf), int'(e.ovf));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waitCycles;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      sel      = 1'b0;
`ifdef ALU_OVF_STICKY_EN
      ovf_clr  = 1'b0;
`endif
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_init", 4'b0000, 1'b0, 1'b0, 1'b0);
`ifdef ALU_OVF_STICKY_EN
      checkField("reset_init.sticky", int'(ovf_sticky), 0);
`endif
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(4'b1111, 4'b1011, 1'b0, 4'b1010, 1'b0, 1'b0);
      applyStimulus(4'b1110, 4'b1110, 1'b1, 4'b0001, 1'b1, 1'b0);
      applyStimulus(4'b1000, 4'b1101, 1'b0, 4'b0101, 1'b0, 1'b1);
      applyStimulus(4'b0101, 4'b0101, 1'b0, 4'b1010, 1'b1, 1'b1);
      idleCycle();
      checkOutput("hold1", 4'b1010, 1'b1, 1'b1, 1'b0);
      idleCycle();
      checkOutput("hold2", 4'b1010, 1'b1, 1'b1, 1'b0);
`ifdef ALU_OVF_STICKY_EN
      checkField("sticky_set", int'(ovf_sticky), 1);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      checkField("sticky_clr", int'(ovf_sticky), 0);
      ovf_clr = 1'b1;
      applyStimulus(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
      ovf_clr = 1'b0;
      checkField("sticky_set_wins", int'(ovf_sticky), 1);
      ovf_clr = 1'b1;
      idleCycle();
      ovf_clr = 1'b0;
      checkField("sticky_clr2", int'(ovf_sticky), 0);
`else
      applyStimulus(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
`endif

      applyStimulus(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
      applyStimulus(4'b0111, 4'b0111, 1'b1, 4'b1000, 1'b1, 1'b0);
      applyStimulus(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0);
      applyStimulus(4'b1100, 4'b0011, 1'b0, 4'b1111, 1'b0, 1'b0);
      idleCycle();
      checkOutput("hold3", 4'b1111, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle, with an input pending that must be discarded.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_async", 4'b0000, 1'b0, 1'b0, 1'b0);
      A        = 4'b0101;
      B        = 4'b0011;
      sel      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_discard", 4'b0000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      idleCycle();
      checkOutput("post_reset_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);
      idleCycle();

      waitCycles = 0;
      while (expQueue.size() != 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      checkField("queue_drained", expQueue.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
